fir_coeff_manager: RTL
======================

// Module: fir_coeff_manager
// PURPOSE
//   Double-buffered coefficient bank and load sequencer for the audio FIR.
//   - A host streams a new tap set into a shadow bank.
//   - The shadow bank is committed to the active bank only on a sample tick
//     (the FIR's data_in_valid), so the FIR never sees a partially updated tap set.
//   - Drives the FIR coeffs port directly.
// PARAMETERS
//   NUM_COEFFS   64                   number of FIR taps
//   COEFF_WIDTH  16                   signed tap width
//   ADDR_WIDTH   $clog2(NUM_COEFFS)   write pointer / readback address width
//   RESET_TAP0   1                    reset value of tap 0 (all other taps reset to 0; gives FIR passthrough)
// PORTS
//   clk          in   1                         system clock
//   rst          in   1                         asynchronous, active-high reset
//   wr_start     in   1                         begin new load, pointer <- 0
//   wr_valid     in   1                         wr_data valid
//   wr_ready     out  1                         manager accepts wr_data
//   wr_data      in   COEFF_WIDTH               signed tap value, written in index order 0..NUM_COEFFS-1
//   wr_last      in   1                         marks the final tap of a load
//   sample_tick  in   1                         FIR data_in_valid; the commit point
//   coeffs       out  [NUM_COEFFS-1:0][COEFF_WIDTH-1:0]  active bank, signed, to FIR
//   busy         out  1                         state != IDLE
//   swap_done    out  1                         one-cycle pulse after commit
//   load_err     out  1                         sticky; malformed load
// BEHAVIOUR
//   Reset (async, all registered):
//     - coeffs = {0,...,0,RESET_TAP0} (tap 0 = RESET_TAP0); shadow bank all 0.
//     - state=IDLE, ptr=0, wr_ready=0, busy=0, swap_done=0, load_err=0.
//   Transfer rule: a tap is accepted iff wr_valid && wr_ready.
//     - wr_valid while wr_ready=0 is ignored.
//   IDLE:
//     - wr_ready=0.
//     - wr_start -> LOAD; ptr<=0; load_err<=0.
//   LOAD:
//     - wr_ready=1.
//     - On accept: shadow[ptr]<=wr_data; ptr<=ptr+1.
//     - Accept with wr_last && ptr==NUM_COEFFS-1 -> PEND.
//     - Accept with wr_last && ptr<NUM_COEFFS-1 -> load_err<=1; -> IDLE; shadow discarded; active unchanged.
//     - Accept with !wr_last && ptr==NUM_COEFFS-1 -> same error handling (no pointer wrap).
//     - wr_start in LOAD restarts: ptr<=0; the wr_start cycle's data is not written.
//   PEND:
//     - wr_ready=0; waits for sample_tick.
//     - On sample_tick: active<=shadow (registered; coeffs change the cycle after the tick);
//       swap_done=1 for that one following cycle; -> IDLE.
//     - The FIR samples coeffs on the tick cycle, so it uses the old set for that sample;
//       the commit is atomic.
//     - wr_start in PEND without tick: abandon pending set; -> LOAD; ptr<=0.
//     - sample_tick && wr_start same cycle: commit wins; wr_start ignored.
//   sample_tick in IDLE/LOAD: no effect.
//   Latency: last accepted tap -> PEND next cycle; tick -> new coeffs 1 cycle.
//   Reset mid-LOAD/PEND: immediate return to reset state; the partial load is lost.
// CONFIGURATION
//   FIR_COEFF_READBACK_EN defined:
//     - Adds ports rd_addr in ADDR_WIDTH and rd_data out COEFF_WIDTH.
//     - rd_data <= coeffs[rd_addr], registered, 1-cycle latency; reset value 0.
//     - Out-of-range rd_addr returns 0.
//   Undefined: ports and logic absent; all other behaviour identical.
// TESTING
//   1 Reset, no stimulus:
//     -> coeffs[0]=1, coeffs[1..63]=0, busy=0, wr_ready=0, load_err=0.
//   2 wr_start; 64 taps value i+1, wr_last on tap 63; hold 10 cycles, no tick:
//     -> coeffs unchanged, busy=1.
//     Then tick -> next cycle coeffs[i]=i+1, swap_done high exactly 1 cycle, busy=0.
//   3 wr_start; 10 taps, wr_last on tap 9:
//     -> load_err=1, IDLE, coeffs unchanged.
//     Next wr_start clears load_err.
//   4 Full load to PEND; drive sample_tick and wr_start in the same cycle:
//     -> commit occurs, state IDLE, no new load started.
//   5 rst asserted asynchronously after 20 accepted taps, no clock edge:
//     -> wr_ready=0, busy=0, coeffs at reset value immediately.
//     After release, a full load commits correctly.
//   6 (FIR_COEFF_READBACK_EN) After test 2, rd_addr=5:
//     -> rd_data=6 one cycle later; rd_addr=63 -> 64.

Source files
------------

// File: rtl/fir_coeff_manager.sv
// ---------------------------------------------------------------------------
// fir_coeff_manager
//
// Double-buffered coefficient bank and load sequencer for the audio FIR.
// A host streams a complete tap set into a shadow bank. The shadow bank is
// copied into the active bank only on a sample tick, so the FIR never sees a
// partially updated tap set. The active bank drives the FIR coeffs port.
//
// Optional feature macro: FIR_COEFF_READBACK_EN
//   When defined, adds a registered readback port (rd_addr / rd_data) into
//   the active bank.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   wr_start     begin a new load (write pointer returns to 0)
//   wr_valid     wr_data is valid
//   wr_ready     manager accepts wr_data (high only while loading)
//   wr_data      signed tap value, written in index order 0..NUM_COEFFS-1
//   wr_last      marks the final tap of a load
//   sample_tick  FIR data_in_valid; the only point where a commit can happen
//   coeffs       active bank, signed taps, to the FIR
//   busy         a load is in progress or waiting for its commit
//   swap_done    one-cycle pulse in the cycle after a commit
//   load_err     sticky flag for a malformed load (cleared by wr_start)
//   rd_addr      (readback only) active-bank tap index
//   rd_data      (readback only) tap value, one cycle after rd_addr
// ---------------------------------------------------------------------------
module fir_coeff_manager #(
  parameter int NUM_COEFFS  = 64,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = $clog2(NUM_COEFFS),
  parameter int RESET_TAP0  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_start,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [COEFF_WIDTH-1:0]                 wr_data,
  input  logic                                   wr_last,
  input  logic                                   sample_tick,
  output logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] coeffs,
  output logic                                   busy,
  output logic                                   swap_done,
  output logic                                   load_err
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0]                  rd_addr,
  output logic [COEFF_WIDTH-1:0]                 rd_data
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COEFFS - 1);

  logic [1:0]                             state;
  logic [ADDR_WIDTH-1:0]                  ptr;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] shadow;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] active;

  logic tap_write;
  logic commit;

  // Handshake outputs are pure decodes of the registered state, so they
  // drop to zero the instant reset is asserted.
  assign wr_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign coeffs   = active;

  // A restart in LOAD takes priority over the data on the same cycle, so
  // that cycle's tap is never written.
  assign tap_write = (state == LOAD) && !wr_start && wr_valid;

  // A tick in PEND always commits, even if wr_start arrives together with it.
  assign commit = (state == PEND) && sample_tick;

  // Load sequencer: pointer, state, error flag and commit pulse. A load is
  // well formed only if wr_last arrives exactly on the final tap; anything
  // else (early wr_last, or running past the final tap) aborts to IDLE and
  // leaves the active bank untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      swap_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start) begin
            state    <= LOAD;
            ptr      <= '0;
            load_err <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_start) begin
            ptr <= '0;
          end else if (wr_valid) begin
            if (ptr == LAST_IDX) begin
              ptr <= '0;
              if (wr_last) begin
                state <= PEND;
              end else begin
                state    <= IDLE;
                load_err <= 1'b1;
              end
            end else if (wr_last) begin
              ptr      <= '0;
              state    <= IDLE;
              load_err <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        PEND: begin
          if (sample_tick) begin
            state     <= IDLE;
            swap_done <= 1'b1;
          end else if (wr_start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Shadow bank: written one tap per accepted transfer. An aborted load
  // simply leaves stale taps here; the next complete load overwrites every
  // entry before it can ever be committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (tap_write) begin
      shadow[ptr] <= wr_data;
    end
  end

  // Active bank: reset to a single unity tap so the FIR passes audio through
  // untouched until the first real tap set is committed. The whole bank is
  // replaced in one clock edge, which keeps the update atomic for the FIR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= '0;
      active[0] <= COEFF_WIDTH'(RESET_TAP0);
    end else if (commit) begin
      active <= shadow;
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  // Registered readback of the active bank; addresses beyond the last tap
  // read as zero rather than aliasing onto a real tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < NUM_COEFFS) begin
      rd_data <= active[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule
